// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, coordinate type and axis-total helpers
// for the 640x480 @ 60 Hz VGA raster generator.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1023;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef logic [COORD_W-1:0] coord_t;

  // Pixels per line, including blanking.
  function automatic int h_total(input int vis, input int fp, input int sy, input int bp);
    return vis + fp + sy + bp;
  endfunction

  // Lines per frame, including blanking.
  function automatic int v_total(input int vis, input int fp, input int sy, input int bp);
    return vis + fp + sy + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one raster axis. Steps on en_i, wraps
// after TOTAL-1 (reporting the wrap combinationally so the next axis can
// step on the same edge) and registers an active-low sync decoded from the
// next count, so sync changes on the same edge as the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output coord_t count_o,
  output logic   wrap_o,
  output logic   active_next_o,
  output logic   sync_n_o
);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_LO = coord_t'(SYNC_START);
  localparam coord_t SYNC_HI = coord_t'(SYNC_START + SYNC_LEN - 1);

  coord_t count_q;
  coord_t count_d;
  logic   wrap_d;
  logic   sync_n_q;
  logic   sync_n_d;

  // Next count: hold, step, or wrap; an out-of-range count also wraps
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (en_i) begin
      if (count_q >= LAST) begin
        count_d = 10'd0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 10'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Sync decode on the next count so it lines up with the count register
  always_comb begin
    sync_n_d = 1'b1;
    if ((count_d >= SYNC_LO) && (count_d <= SYNC_HI)) begin
      sync_n_d = 1'b0;
    end else begin
      sync_n_d = 1'b1;
    end
  end

  // Count and sync registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= 10'd0;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count_o       = count_q;
  assign wrap_o        = wrap_d;
  assign active_next_o = (count_d < ACT_END);
  assign sync_n_o      = sync_n_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (default 640x480 @ 60 Hz).
// Build option: define VGA_PIXEL_DIV_EN to derive a half-rate pixel enable
// from Clk (50 MHz Clk -> 25 MHz pixels, VGA_CLK = registered toggle).
// Without it the pixel enable is held high and VGA_CLK passes Clk through.
// All strobes are registered from next-position decodes, so they move on
// the same Clk edge as DrawX/DrawY.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   VGA_CLK,
  output logic   VGA_HS,
  output logic   VGA_VS,
  output logic   VGA_BLANK_N,
  output logic   VGA_SYNC_N,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_start
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  generate
    if ((H_TOTAL > COORD_MAX) || (V_TOTAL > COORD_MAX)) begin : g_total_range_err
      $error("vga_sync_gen: raster totals exceed the 10-bit coordinate range");
    end
  endgenerate

  logic pix_en_s;

`ifdef VGA_PIXEL_DIV_EN
  logic pix_en_q;

  // Half-rate pixel enable; doubles as the DAC pixel clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= ~pix_en_q;
    end
  end

  assign pix_en_s = pix_en_q;
  assign VGA_CLK  = pix_en_q;
`else
  assign pix_en_s = 1'b1;
  assign VGA_CLK  = Clk;
`endif

  logic h_wrap_s;
  logic h_act_s;
  logic v_wrap_s;
  logic v_act_s;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk_i         (Clk),
    .rst_i         (Reset),
    .en_i          (pix_en_s),
    .count_o       (DrawX),
    .wrap_o        (h_wrap_s),
    .active_next_o (h_act_s),
    .sync_n_o      (VGA_HS)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk_i         (Clk),
    .rst_i         (Reset),
    .en_i          (h_wrap_s),
    .count_o       (DrawY),
    .wrap_o        (v_wrap_s),
    .active_next_o (v_act_s),
    .sync_n_o      (VGA_VS)
  );

  logic blank_n_q;
  logic blank_n_d;
  logic frame_start_q;
  logic frame_start_d;

  // Blank only updates on a pixel step, keeping (0,0) after reset blanked
  // until the first real advance; frame_start marks the step into (0,0)
  always_comb begin
    blank_n_d     = blank_n_q;
    frame_start_d = v_wrap_s;
    if (pix_en_s) begin
      blank_n_d = h_act_s & v_act_s;
    end else begin
      blank_n_d = blank_n_q;
    end
  end

  // Frame-level strobe registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign VGA_BLANK_N = blank_n_q;
  assign frame_start = frame_start_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen. A small-raster
// instance (32x19) exercises whole frames quickly; a default-raster
// instance covers real 640x480 line timing. Expected values come from an
// arithmetic model: position = (pixel steps since reset) mod frame size.
module tb_vga_sync_gen;

`ifdef VGA_PIXEL_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  localparam int SHV = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = 32;
  localparam int SFRAME = 608;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       sCK, sHS, sVS, sBL, sSN, sFS;
  logic [9:0] sX, sY;
  logic       fCK, fHS, fVS, fBL, fSN, fFS;
  logic [9:0] fX, fY;

  int errors = 0;
  int checks = 0;
  int k = 0;

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_small (
    .Clk(Clk), .Reset(Reset), .VGA_CLK(sCK), .VGA_HS(sHS), .VGA_VS(sVS),
    .VGA_BLANK_N(sBL), .VGA_SYNC_N(sSN), .DrawX(sX), .DrawY(sY), .frame_start(sFS)
  );

  vga_sync_gen dut_full (
    .Clk(Clk), .Reset(Reset), .VGA_CLK(fCK), .VGA_HS(fHS), .VGA_VS(fVS),
    .VGA_BLANK_N(fBL), .VGA_SYNC_N(fSN), .DrawX(fX), .DrawY(fY), .frame_start(fFS)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {x, y, hs_n, vs_n, blank_n, frame_start} after kk Clk edges
  function automatic logic [23:0] model(input int kk, input int hv, input int hf,
      input int hsw, input int hb, input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, n, p, x, y;
    logic hs_n, vs_n, bl, fs;
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    n    = kk / DIV;
    p    = n % (ht * vt);
    x    = p % ht;
    y    = p / ht;
    hs_n = !((x >= hv + hf) && (x < hv + hf + hsw));
    vs_n = !((y >= vv + vf) && (y < vv + vf + vsw));
    bl   = (n > 0) && (x < hv) && (y < vv);
    fs   = (kk > 0) && ((kk % DIV) == 0) && (p == 0);
    return {x[9:0], y[9:0], hs_n, vs_n, bl, fs};
  endfunction

  function automatic logic [23:0] model_s(input int kk);
    return model(kk, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic logic [23:0] model_f(input int kk);
    return model(kk, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  task automatic tick();
    @(posedge Clk);
    if (!Reset) k = k + 1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [24:0] want;
    want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    Reset = 1'b1;
    k = 0;
    repeat (3) tick();
    checks++;
    if ({sX, sY, sHS, sVS, sBL, sFS, sSN} !== want) begin
      errors++; $display("FAIL reset_small got %h want %h", {sX, sY, sHS, sVS, sBL, sFS, sSN}, want);
    end
    checks++;
    if ({fX, fY, fHS, fVS, fBL, fFS, fSN} !== want) begin
      errors++; $display("FAIL reset_full got %h want %h", {fX, fY, fHS, fVS, fBL, fFS, fSN}, want);
    end
    Reset = 1'b0;
    repeat (37) tick();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({sX, sY, sHS, sVS, sBL, sFS, sSN} !== want) begin
      errors++; $display("FAIL async_reset_small got %h want %h", {sX, sY, sHS, sVS, sBL, sFS, sSN}, want);
    end
    checks++;
    if ({fX, fY, fHS, fVS, fBL, fFS, fSN} !== want) begin
      errors++; $display("FAIL async_reset_full got %h want %h", {fX, fY, fHS, fVS, fBL, fFS, fSN}, want);
    end
    @(negedge Clk);
    Reset = 1'b0;
    k = 0;
  endtask

  task automatic test_full_line();
    logic prev_hs;
    int   low_len;
    prev_hs = fHS;
    low_len = 0;
    for (int c = 0; c < 3 * 800 * DIV; c++) begin
      tick();
      checks++;
      if ({fX, fY, fHS, fVS, fBL, fFS} !== model_f(k)) begin
        errors++;
        if (errors < 50) $display("FAIL full_cycle k=%0d got %h want %h", k, {fX, fY, fHS, fVS, fBL, fFS}, model_f(k));
      end
      if (prev_hs && !fHS) begin
        checks++;
        if (fX !== 10'd656) begin errors++; $display("FAIL hs_fall_x got %0d want 656", fX); end
        low_len = 0;
      end
      if (!fHS) low_len++;
      if (!prev_hs && fHS) begin
        checks++;
        if (fX !== 10'd752) begin errors++; $display("FAIL hs_rise_x got %0d want 752", fX); end
        checks++;
        if (low_len != 96 * DIV) begin errors++; $display("FAIL hs_width got %0d want %0d", low_len, 96 * DIV); end
      end
      prev_hs = fHS;
    end
    checks++;
    if ((fX !== 10'd0) || (fY !== 10'd3)) begin
      errors++; $display("FAIL line_wrap got (%0d,%0d) want (0,3)", fX, fY);
    end
  endtask

  task automatic test_small_frames();
    int   fs_cnt, last_fs, bl_cnt, vs_len;
    logic prev_vs;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    k = 0;
    fs_cnt = 0; last_fs = 0; bl_cnt = 0; vs_len = 0;
    prev_vs = sVS;
    for (int c = 0; c < 3 * SFRAME * DIV; c++) begin
      tick();
      checks++;
      if ({sX, sY, sHS, sVS, sBL, sFS} !== model_s(k)) begin
        errors++;
        if (errors < 50) $display("FAIL small_cycle k=%0d got %h want %h", k, {sX, sY, sHS, sVS, sBL, sFS}, model_s(k));
      end
      if (sFS) begin
        if (fs_cnt > 0) begin
          checks++;
          if (k - last_fs != SFRAME * DIV) begin
            errors++; $display("FAIL fs_period got %0d want %0d", k - last_fs, SFRAME * DIV);
          end
        end
        fs_cnt++;
        last_fs = k;
      end
      if ((fs_cnt == 1) && sBL) bl_cnt++;
      if (prev_vs && !sVS) begin
        checks++;
        if ((sX !== 10'd0) || (sY !== 10'd14)) begin
          errors++; $display("FAIL vs_fall_pos got (%0d,%0d) want (0,14)", sX, sY);
        end
        vs_len = 0;
      end
      if (!sVS) vs_len++;
      if (!prev_vs && sVS) begin
        checks++;
        if ((sX !== 10'd0) || (sY !== 10'd16)) begin
          errors++; $display("FAIL vs_rise_pos got (%0d,%0d) want (0,16)", sX, sY);
        end
        checks++;
        if (vs_len != 2 * SHT * DIV) begin
          errors++; $display("FAIL vs_width got %0d want %0d", vs_len, 2 * SHT * DIV);
        end
      end
      prev_vs = sVS;
    end
    checks++;
    if (fs_cnt != 3) begin errors++; $display("FAIL fs_count got %0d want 3", fs_cnt); end
    checks++;
    if (bl_cnt != SHV * SVV * DIV) begin
      errors++; $display("FAIL blank_count got %0d want %0d", bl_cnt, SHV * SVV * DIV);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    logic done;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    k = 0;
    while (k < (7 * SHT + 10) * DIV) begin
      tick();
      checks++;
      if ({sX, sY, sHS, sVS, sBL, sFS} !== model_s(k)) begin
        errors++;
        if (errors < 50) $display("FAIL mid_cycle k=%0d got %h want %h", k, {sX, sY, sHS, sVS, sBL, sFS}, model_s(k));
      end
    end
    checks++;
    if ((sX !== 10'd10) || (sY !== 10'd7)) begin
      errors++; $display("FAIL mid_pos got (%0d,%0d) want (10,7)", sX, sY);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({sX, sY, sHS, sVS, sBL, sFS} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got %h want 0000c", {sX, sY, sHS, sVS, sBL, sFS});
    end
    @(negedge Clk);
    Reset = 1'b0;
    k = 0;
    repeat (DIV) tick();
    checks++;
    if ((sX !== 10'd1) || (sY !== 10'd0)) begin
      errors++; $display("FAIL first_step_small got (%0d,%0d) want (1,0)", sX, sY);
    end
    checks++;
    if ((fX !== 10'd1) || (fY !== 10'd0)) begin
      errors++; $display("FAIL first_step_full got (%0d,%0d) want (1,0)", fX, fY);
    end
    n = 0;
    done = 1'b0;
    while (!done && (n < 2 * SFRAME * DIV)) begin
      tick();
      n++;
      if (!sVS) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL vs_timeout got no VS fall want one"); end
    checks++;
    if ((sX !== 10'd0) || (sY !== 10'd14)) begin
      errors++; $display("FAIL first_vs_pos got (%0d,%0d) want (0,14)", sX, sY);
    end
    checks++;
    if (k != 14 * SHT * DIV) begin
      errors++; $display("FAIL first_vs_time got %0d want %0d", k, 14 * SHT * DIV);
    end
  endtask

  task automatic test_random_reset();
    int len, off, hold;
    repeat (6) begin
      len = $urandom_range(1, 2 * SFRAME * DIV);
      for (int c = 0; c < len; c++) begin
        tick();
        checks++;
        if ({sX, sY, sHS, sVS, sBL, sFS} !== model_s(k)) begin
          errors++;
          if (errors < 50) $display("FAIL rnd_small k=%0d got %h want %h", k, {sX, sY, sHS, sVS, sBL, sFS}, model_s(k));
        end
        checks++;
        if ({fX, fY, fHS, fVS, fBL, fFS} !== model_f(k)) begin
          errors++;
          if (errors < 50) $display("FAIL rnd_full k=%0d got %h want %h", k, {fX, fY, fHS, fVS, fBL, fFS}, model_f(k));
        end
      end
      off = $urandom_range(1, 3);
      #(off);
      Reset = 1'b1;
      #1;
      checks++;
      if ({sX, sY, sHS, sVS, sBL, sFS, fX, fY, fHS, fVS, fBL, fFS} !==
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rnd_async_reset got %h want 00000c00000c", {sX, sY, sHS, sVS, sBL, sFS, fX, fY, fHS, fVS, fBL, fFS});
      end
      hold = $urandom_range(0, 2);
      repeat (hold) tick();
      @(negedge Clk);
      Reset = 1'b0;
      k = 0;
    end
  endtask

  task automatic test_vga_clk();
    logic want;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk);
      k = k + 1;
      #1;
      want = (DIV == 1) ? 1'b1 : ((k % 2) == 1);
      checks++;
      if ((sCK !== want) || (fCK !== want)) begin
        errors++; $display("FAIL vga_clk_high k=%0d got %b/%b want %b", k, sCK, fCK, want);
      end
      @(negedge Clk);
      want = (DIV == 1) ? 1'b0 : ((k % 2) == 1);
      checks++;
      if ((sCK !== want) || (fCK !== want)) begin
        errors++; $display("FAIL vga_clk_low k=%0d got %b/%b want %b", k, sCK, fCK, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_small_frames();
    test_reset_midframe();
    test_random_reset();
    test_vga_clk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
